// File: rtl/aes128_iterative_encrypt.sv
// -----------------------------------------------------------------------------
// aes128_iterative_encrypt
//
// Iterative AES-128 encryption core. One 128-bit plaintext/key pair is taken
// per valid/ready handshake, one AES round is executed per clock with the
// round key expanded on the fly, and the ciphertext is presented on a held
// valid/ready output. A single round of hardware is reused ten times.
//
// Ports
//   clk_i        single clock, all logic on the rising edge
//   rst_i        synchronous, active-high reset
//   key_i        cipher key, byte 0 = bits [127:120]
//   text_i       plaintext, byte 0 = bits [127:120], column-major state
//   in_valid_i   key_i/text_i valid
//   in_ready_o   core can accept a block
//   chipher_o    ciphertext, stable while out_valid_o is high
//   out_valid_o  chipher_o valid
//   out_ready_i  consumer accepts chipher_o
//   busy_o       high while rounds are being computed
//
// Configuration macro
//   AES_BACK2BACK_EN  when defined, a block can be loaded on the same edge
//                     that retires the previous result (DONE -> RUN), giving
//                     11 cycles per block instead of 12.
// -----------------------------------------------------------------------------
module aes128_iterative_encrypt (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [127:0] key_i,
  input  logic [127:0] text_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [127:0] chipher_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         busy_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  // Forward S-box, byte x lives at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    // 2047 - 8*x == {~x, 3'b111}
    return SBOX_TABLE[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Row r of the column-major state rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127 - 8*(w + 4*c) -: 8] = s[127 - 8*(w + 4*((c + w) % 4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = col[31 - 8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      r[31 - 8*i -: 8] = xtime(a[i]) ^ xtime(a[(i + 1) % 4]) ^ a[(i + 1) % 4]
                         ^ a[(i + 2) % 4] ^ a[(i + 3) % 4];
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One step of the AES-128 key schedule: previous round key -> next.
  function automatic logic [127:0] key_expansion(input logic [3:0] round,
                                                 input logic [127:0] key);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = key;
    t  = {sbox(w3[23:16]) ^ rcon(round), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, rkey_q;
  logic [3:0]   round_q;

  logic         accept;
  logic         last_round;
  logic [127:0] next_key;
  logic [127:0] shifted;
  logic [127:0] round_state;

  assign accept      = in_valid_i & in_ready_o;
  assign last_round  = (round_q == 4'd10);
  assign next_key    = key_expansion(round_q, rkey_q);
  assign shifted     = shift_rows(sub_bytes(state_q));
  // The final round omits MixColumns.
  assign round_state = (last_round ? shifted : mix_columns(shifted)) ^ next_key;

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst_i) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // fsm_d unassigned and no latch is inferred.
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: if (accept) fsm_d = RUN;
      RUN:  if (last_round) fsm_d = DONE;
      DONE: if (out_ready_i) fsm_d = accept ? RUN : IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (fsm_q)
      IDLE: in_ready_o = 1'b1;
      RUN:  busy_o     = 1'b1;
      DONE: begin
        out_valid_o = 1'b1;
`ifdef AES_BACK2BACK_EN
        in_ready_o  = out_ready_i;
`else
        in_ready_o  = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // Datapath: load on accept, otherwise one round per clock while running.
  always_ff @(posedge clk_i) begin
    // NOTE: all datapath registers take the reset so chipher_o reads zero and
    // an aborted block leaves nothing behind; the S-box is a constant table
    // and has no state to reset.
    if (rst_i) begin
      state_q <= '0;
      rkey_q  <= '0;
      round_q <= '0;
    end else if (accept) begin
      state_q <= text_i ^ key_i;
      rkey_q  <= key_i;
      round_q <= 4'd1;
    end else if (fsm_q == RUN) begin
      state_q <= round_state;
      rkey_q  <= next_key;
      if (!last_round) round_q <= round_q + 4'd1;
    end
  end

  assign chipher_o = state_q;

endmodule

// File: tb/tb_aes128_iterative_encrypt.sv
// -----------------------------------------------------------------------------
// tb_aes128_iterative_encrypt
//
// Scoreboard bench for aes128_iterative_encrypt. Stimulus pushes the expected
// ciphertext (FIPS-197 constants or a byte-array AES model built from GF(2^8)
// arithmetic) when a block is accepted; an independent monitor compares the
// output while out_valid_o is high, checks 10-cycle latency, and runs a
// reference inverse cipher on the result to recover the plaintext.
// Honours AES_BACK2BACK_EN for the expected block spacing.
// -----------------------------------------------------------------------------
module tb_aes128_iterative_encrypt;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [127:0] key_i, text_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] chipher_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic         busy_o;

  aes128_iterative_encrypt dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .key_i       (key_i),
    .text_i      (text_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .chipher_o   (chipher_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

`ifdef AES_BACK2BACK_EN
  localparam int SPACING = 11;
`else
  localparam int SPACING = 12;
`endif

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_TEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_TEXT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;

  typedef struct {
    logic [127:0] key;
    logic [127:0] text;
    logic [127:0] cipher;
    int           acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   rise_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ready_mode = 1;  // 0 low, 1 high, 2 random
  logic prev_valid = 1'b0;

  logic [7:0] sbox_m [256];
  logic [7:0] inv_sbox_m [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
  endtask

  // ---------------- reference model (byte arrays, GF(2^8) arithmetic) -------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] bx, inv, s;
      bx  = 8'(x);
      inv = '0;
      for (int y = 1; y < 256; y++) if (bx != 0 && gmul(bx, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_m[x]     = s;
      inv_sbox_m[s] = bx;
    end
  endtask

  // Full key schedule from scratch, returning round key k.
  function automatic logic [127:0] round_key(input logic [127:0] key, input int k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox_m[t[23:16]] ^ rc, sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] rk, res;
    rk = round_key(key, 0);
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[127 - 8*i -: 8];
    for (int k = 1; k <= 10; k++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (k < 10)
            s[4*c + r] = gmul(t[4*c + r], 8'h02) ^ gmul(t[4*c + (r+1)%4], 8'h03)
                       ^ t[4*c + (r+2)%4] ^ t[4*c + (r+3)%4];
          else
            s[4*c + r] = t[4*c + r];
      rk = round_key(key, k);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // Reference inverse cipher.
  function automatic logic [127:0] model_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] rk, res;
    rk = round_key(key, 10);
    for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ rk[127 - 8*i -: 8];
    for (int k = 9; k >= 0; k--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*((c + r) % 4)] = s[r + 4*c];
      rk = round_key(key, k);
      for (int i = 0; i < 16; i++) t[i] = inv_sbox_m[t[i]] ^ rk[127 - 8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (k > 0)
            s[4*c + r] = gmul(t[4*c + r], 8'h0e) ^ gmul(t[4*c + (r+1)%4], 8'h0b)
                       ^ gmul(t[4*c + (r+2)%4], 8'h0d) ^ gmul(t[4*c + (r+3)%4], 8'h09);
          else
            s[4*c + r] = t[4*c + r];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- consumer ready driver -----------------------------------
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready_i = 1'b0;
        1:       out_ready_i = 1'b1;
        default: out_ready_i = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // ---------------- monitor --------------------------------------------------
  always @(negedge clk) begin
    if (rst_i) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_output");
        end else begin
          if (!prev_valid) begin
            rise_q.push_back(cyc);
            check("latency", 128'(cyc - exp_q[0].acc_cyc), 128'd10);
          end
          check("ciphertext", chipher_o, exp_q[0].cipher);
          if (out_ready_i) begin
            check("decrypt_roundtrip", model_decrypt(exp_q[0].key, chipher_o), exp_q[0].text);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_valid = out_valid_o;
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  // Entered and left just after a rising edge; in_valid_i stays high on return.
  task automatic send(input logic [127:0] k, input logic [127:0] t, input logic [127:0] c);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    key_i = k; text_i = t; in_valid_i = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready_o) begin
        e.key = k; e.text = t; e.cipher = c; e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) timeout_fail("send_accept");
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy_o && !out_valid_o) done = 1'b1;
    end
    if (!done) timeout_fail("drain");
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    bit seen;
    rst_i = 1'b1; key_i = '0; text_i = '0; in_valid_i = 1'b0;
    build_tables();

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 128'(in_ready_o), 128'd1);
    check("reset_out_valid", 128'(out_valid_o), 128'd0);
    check("reset_busy", 128'(busy_o), 128'd0);
    check("reset_cipher", chipher_o, 128'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // FIPS-197 C.1.
    ready_mode = 1;
    send(C1_KEY, C1_TEXT, C1_CT);
    in_valid_i = 1'b0;
    wait_drain();

    // Appendix B with a 20-cycle consumer stall.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(B_KEY, B_TEXT, B_CT);
    in_valid_i = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (out_valid_o) seen = 1'b1;
    end
    if (!seen) timeout_fail("stall_valid_rise");
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("stall_valid_held", 128'(out_valid_o), 128'd1);
    end
    ready_mode = 1;
    @(negedge clk);  // out_ready_i high here; handshake on the next edge
    @(negedge clk);
    check("stall_back_idle_valid", 128'(out_valid_o), 128'd0);
    check("stall_back_idle_ready", 128'(in_ready_o), 128'd1);
    @(posedge clk); #1;
    wait_drain();

    // Corrupt inputs and toggle in_valid_i while running.
    send(C1_KEY, C1_TEXT, C1_CT);
    for (int n = 0; n < 8; n++) begin
      key_i      = {$urandom(), $urandom(), $urandom(), $urandom()};
      text_i     = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid_i = 1'($urandom_range(1, 0));
      @(negedge clk);
      check("run_in_ready_low", 128'(in_ready_o), 128'd0);
      check("run_busy", 128'(busy_o), 128'd1);
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    wait_drain();

    // Reset at round 5, then C.1 again.
    send(C1_KEY, C1_TEXT, C1_CT);
    in_valid_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 128'(in_ready_o), 128'd1);
    check("abort_busy", 128'(busy_o), 128'd0);
    check("abort_cipher", chipher_o, 128'd0);
    for (int n = 0; n < 12; n++) begin
      check("abort_no_output", 128'(out_valid_o), 128'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    send(C1_KEY, C1_TEXT, C1_CT);
    in_valid_i = 1'b0;
    wait_drain();

    // Back-to-back stream with an always-ready consumer.
    rise_q.delete();
    send(C1_KEY, C1_TEXT, C1_CT);
    send(B_KEY, B_TEXT, B_CT);
    in_valid_i = 1'b0;
    wait_drain();
    if (rise_q.size() == 2) check("stream_spacing", 128'(rise_q[1] - rise_q[0]), 128'(SPACING));
    else check("stream_rise_count", 128'(rise_q.size()), 128'd2);

    // Random blocks with a random consumer.
    ready_mode = 2;
    for (int n = 0; n < 1000; n++) begin
      logic [127:0] k, t;
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(k, t, model_encrypt(k, t));
      if ($urandom_range(3, 0) == 0) begin
        in_valid_i = 1'b0;
        repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
      end
    end
    in_valid_i = 1'b0;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
